// File: rtl/multi_port_register_file_pkg.sv
// Shared datapath constants: default data width and the address-width helper.
// Constant-only package; no logic, no latency, no backpressure.
package multi_port_register_file_pkg;

  localparam int DATA_WIDTH_DEF = 16;

  // Address width for a given depth, never narrower than one bit.
  function automatic int clog2Min1(input int n);
    int w;
    w = 1;
    while ((32'sd1 << w) < n) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One read port: range check, storage mux, write bypass, optional output register.
// Latency 0 or 1 cycle (READ_LATENCY); no backpressure, new address accepted every cycle.
module regfile_read_port
  import multi_port_register_file_pkg::*;
#(
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int DEPTH        = 8,
  parameter int AW           = clog2Min1(DEPTH),
  parameter int BYPASS       = 1,
  parameter int ZERO_REG     = 0,
  parameter int READ_LATENCY = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [AW-1:0]           rdAddr,
  input  logic [DATA_WIDTH-1:0]   storage [DEPTH],
  input  logic [1:0]              wrtHitEn,
  input  logic [2*AW-1:0]         wrtAddr,
  input  logic [2*DATA_WIDTH-1:0] wrtData,
  output logic [DATA_WIDTH-1:0]   rdData
);

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] readVal;
  logic [DATA_WIDTH-1:0] rdReg;
  logic                  addrOk;

  assign addrOk = ({1'b0, rdAddr} < DEPTH_L) && !((ZERO_REG != 0) && (rdAddr == '0));

  // Port 1 is checked last so it overrides port 0 when both hit.
  always_comb begin
    readVal = '0;
    if (addrOk) begin
      readVal = storage[rdAddr];
      if (BYPASS != 0) begin
        if (wrtHitEn[0] && (wrtAddr[0 +: AW] == rdAddr))
          readVal = wrtData[0 +: DATA_WIDTH];
        if (wrtHitEn[1] && (wrtAddr[AW +: AW] == rdAddr))
          readVal = wrtData[DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rdReg <= '0;
    else     rdReg <= readVal;
  end

  assign rdData = (READ_LATENCY != 0) ? rdReg : readVal;

endmodule

// File: rtl/multi_port_register_file.sv
// Parametrised 2W/NR register file with fixed write priority, bypass and conflict flag.
// Read latency 0 or 1 cycle; writes land at the next edge; no backpressure.
module multi_port_register_file
  import multi_port_register_file_pkg::*;
#(
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int DEPTH        = 8,
  parameter int NUM_RD       = 2,
  parameter int BYPASS       = 1,
  parameter int ZERO_REG     = 0,
  parameter int READ_LATENCY = 0,
  localparam int AW          = clog2Min1(DEPTH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_RD*AW-1:0]         rdAddr,
  output logic [NUM_RD*DATA_WIDTH-1:0] rdData,
  input  logic [1:0]                   wrtEnable,
  input  logic [2*AW-1:0]              wrtAddr,
  input  logic [2*DATA_WIDTH-1:0]      wrtData,
  output logic                         wrtConflict
);

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic [AW-1:0]         wrtAddrP [2];
  logic [DATA_WIDTH-1:0] wrtDataP [2];
  logic [1:0]            wrtValid;
  logic [1:0]            wrtHitEn;

  // A write counts only if in range and not aimed at the hardwired zero register.
  always_comb begin
    for (int j = 0; j < 2; j++) begin
      wrtAddrP[j] = wrtAddr[j*AW +: AW];
      wrtDataP[j] = wrtData[j*DATA_WIDTH +: DATA_WIDTH];
      wrtValid[j] = wrtEnable[j] && ({1'b0, wrtAddrP[j]} < DEPTH_L)
                    && !((ZERO_REG != 0) && (wrtAddrP[j] == '0));
    end
  end

  assign wrtHitEn = wrtValid & {2{~rst}};

  // Port 1 is applied last, so it wins on a shared address.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      wrtConflict <= 1'b0;
    end else begin
      for (int j = 0; j < 2; j++)
        if (wrtValid[j]) regs[wrtAddrP[j]] <= wrtDataP[j];
      wrtConflict <= wrtValid[0] && wrtValid[1] && (wrtAddrP[0] == wrtAddrP[1]);
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : gRd
    regfile_read_port #(
      .DATA_WIDTH  (DATA_WIDTH),
      .DEPTH       (DEPTH),
      .AW          (AW),
      .BYPASS      (BYPASS),
      .ZERO_REG    (ZERO_REG),
      .READ_LATENCY(READ_LATENCY)
    ) uRd (
      .clk     (clk),
      .rst     (rst),
      .rdAddr  (rdAddr[k*AW +: AW]),
      .storage (regs),
      .wrtHitEn(wrtHitEn),
      .wrtAddr (wrtAddr),
      .wrtData (wrtData),
      .rdData  (rdData[k*DATA_WIDTH +: DATA_WIDTH])
    );
  end

endmodule
